pwm_duty_sequencer: RTL and testbench
=====================================

// Module: pwm_duty_sequencer
// PURPOSE
//  Owns the duty-cycle register of the PWM core: arbitrates duty requests from the debounced
//  inc/dec buttons and a host command port, then ramps the applied duty toward the target.
//  Duty changes only at PWM period boundaries (period_end from the PWM core), so no output
//  period is ever truncated or glitched. Sits between the debouncers/host and the PWM core.
// PARAMETERS
//  DW            4   duty/target width, bits
//  MIN_DUTY      1   lowest duty reachable by any request
//  MAX_DUTY      9   highest duty reachable by any request (must be < 2**DW)
//  DEFAULT_DUTY  5   target, and applied duty, out of reset
//  RAMP_DIV      1   period_end pulses per 1-LSB ramp step (>=1)
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   reset, synchronous, active-low
//  inc_pulse   in   1   debounced 1-cycle request: target+1
//  dec_pulse   in   1   debounced 1-cycle request: target-1
//  cmd_valid   in   1   host absolute-duty command valid
//  cmd_duty    in   DW  host requested duty
//  cmd_ready   out  1   host command accepted when cmd_valid&&cmd_ready
//  period_end  in   1   1-cycle pulse from PWM core on last count of each period
//  duty_out    out  DW  applied duty to PWM core
//  target      out  DW  current target duty
//  busy        out  1   1 while duty_out != target (RAMP state)
//  err_range   out  1   1-cycle pulse: host cmd_duty outside [MIN_DUTY,MAX_DUTY] was clamped
// BEHAVIOUR
//  Reset: duty_out=target=DEFAULT_DUTY, busy=0, err_range=0, cmd_ready=1, pendings cleared,
//   ramp count=0, last_grant=BTN; state IDLE. Reset mid-ramp aborts the ramp immediately.
//  Host: cmd_ready = !host_pend. Accept registers cmd_duty into host_pend/host_val.
//  Buttons: inc_pulse sets inc_pend, dec_pulse sets dec_pend; inc and dec in the same cycle
//   cancel (neither set). A new button pulse replaces an older pending one of opposite sense.
//  Arbiter: each cycle, if only one source pending it is granted; if both, round-robin
//   against last_grant. Grant clears that pending flag; target updates on the same edge.
//   Latency: accept at edge N -> target earliest at edge N+1.
//  Target arithmetic: host value clamped to [MIN_DUTY,MAX_DUTY] (err_range pulses if clamped);
//   inc at MAX_DUTY or dec at MIN_DUTY is dropped silently. Arithmetic DW+1 bits, no wrap.
//  FSM: IDLE (duty_out==target) -> RAMP when target changes to a different value.
//   RAMP: ramp count increments on period_end; on reaching RAMP_DIV it resets to 0 and
//   duty_out steps 1 LSB toward target. RAMP -> IDLE when duty_out==target.
//   Target changes during RAMP retarget without resetting the ramp count; reversal allowed.
//  period_end coincident with a grant: step uses the pre-grant target.
// CONFIGURATION
//  PWM_SOFTSTART_EN defined: reset loads duty_out=0, target=DEFAULT_DUTY, state RAMP, busy=1;
//   duty ramps up from 0 at the normal rate. Not defined: duty_out=DEFAULT_DUTY at reset.
// STRUCTURE
//  Shared package pwm_pkg: state enum (ST_IDLE, ST_RAMP), grant enum (GNT_BTN, GNT_HOST),
//   default DW/MIN/MAX/DEFAULT duty constants shared with the PWM core.
//  One sub-module: pwm_req_arbiter (pending flags, round-robin grant, cmd_ready).
//  Ramp FSM, clamp and ramp counter stay in this module.
// TESTING
//  1 Reset, no requests, 20 period_end pulses -> duty_out=5, target=5, busy=0 throughout.
//  2 Host cmd_duty=8, RAMP_DIV=1 -> target=8 next edge; duty_out 6,7,8 on next three
//    period_end pulses, then busy=0.
//  3 Host cmd_duty=15 -> err_range pulses 1 cycle, target=9; cmd_duty=0 -> target=1.
//  4 inc_pulse and cmd_valid (cmd_duty=2) same cycle, last_grant=BTN -> host first (target=2),
//    then button (target=3); cmd_ready low only while host_pend set.
//  5 target=9, inc_pulse x3 -> target stays 9; inc and dec same cycle -> no change.
//  6 Mid-ramp (duty_out=6 -> 8) assert rst_n=0 one cycle -> duty_out=5, busy=0 next edge;
//    with PWM_SOFTSTART_EN: duty_out=0, then 1..5 over 5 period_end pulses.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM constants, FSM state encodings and grant source type.
package pwm_pkg;

  localparam int unsigned PWM_DW           = 4;
  localparam int unsigned PWM_MIN_DUTY     = 1;
  localparam int unsigned PWM_MAX_DUTY     = 9;
  localparam int unsigned PWM_DEFAULT_DUTY = 5;
  localparam int unsigned PWM_RAMP_DIV     = 1;

  // Ramp FSM states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;

  // Request source that won the last arbitration.
  typedef enum logic {
    GNT_BTN  = 1'b0,
    GNT_HOST = 1'b1
  } grant_e;

endpackage

// File: rtl/pwm_req_arbiter.sv
// Holds pending button/host duty requests and grants one per cycle, round-robin on conflict.
module pwm_req_arbiter
  import pwm_pkg::*;
#(
  parameter int unsigned DW = PWM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_pulse_i,
  input  logic          dec_pulse_i,
  input  logic          cmd_valid_i,
  input  logic [DW-1:0] cmd_duty_i,
  output logic          cmd_ready_o,
  output logic          gnt_valid_c,
  output grant_e        gnt_src_c,
  output logic          gnt_inc_c,
  output logic [DW-1:0] host_val_o
);

  logic          inc_pend_q, inc_pend_d;
  logic          dec_pend_q, dec_pend_d;
  logic          host_pend_q, host_pend_d;
  logic [DW-1:0] host_val_q, host_val_d;
  grant_e        last_grant_q, last_grant_d;
  logic          btn_pend;

  // Pending-flag and last-grant registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc_pend_q   <= 1'b0;
      dec_pend_q   <= 1'b0;
      host_pend_q  <= 1'b0;
      host_val_q   <= '0;
      last_grant_q <= GNT_BTN;
    end else begin
      inc_pend_q   <= inc_pend_d;
      dec_pend_q   <= dec_pend_d;
      host_pend_q  <= host_pend_d;
      host_val_q   <= host_val_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grant selection and pending-flag update; new pulses win over a same-cycle clear.
  always_comb begin
    btn_pend     = inc_pend_q | dec_pend_q;
    gnt_valid_c  = btn_pend | host_pend_q;
    gnt_src_c    = host_pend_q ? GNT_HOST : GNT_BTN;
    inc_pend_d   = inc_pend_q;
    dec_pend_d   = dec_pend_q;
    host_pend_d  = host_pend_q;
    host_val_d   = host_val_q;
    last_grant_d = last_grant_q;

    if (btn_pend && host_pend_q) begin
      gnt_src_c = (last_grant_q == GNT_BTN) ? GNT_HOST : GNT_BTN;
    end

    if (gnt_valid_c) begin
      last_grant_d = gnt_src_c;
      if (gnt_src_c == GNT_BTN) begin
        inc_pend_d = 1'b0;
        dec_pend_d = 1'b0;
      end else begin
        host_pend_d = 1'b0;
      end
    end

    if (inc_pulse_i && !dec_pulse_i) begin
      inc_pend_d = 1'b1;
      dec_pend_d = 1'b0;
    end else if (dec_pulse_i && !inc_pulse_i) begin
      dec_pend_d = 1'b1;
      inc_pend_d = 1'b0;
    end

    if (cmd_valid_i && !host_pend_q) begin
      host_pend_d = 1'b1;
      host_val_d  = cmd_duty_i;
    end
  end

  assign gnt_inc_c   = inc_pend_q;
  assign host_val_o  = host_val_q;
  assign cmd_ready_o = ~host_pend_q;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// PWM duty sequencer: arbitrates duty requests and ramps duty_out toward target at period ends.
// Optional feature macro: PWM_SOFTSTART_EN (reset duty_out to 0 and ramp up to the default).
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned DW           = PWM_DW,
  parameter int unsigned MIN_DUTY     = PWM_MIN_DUTY,
  parameter int unsigned MAX_DUTY     = PWM_MAX_DUTY,
  parameter int unsigned DEFAULT_DUTY = PWM_DEFAULT_DUTY,
  parameter int unsigned RAMP_DIV     = PWM_RAMP_DIV
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_pulse,
  input  logic          dec_pulse,
  input  logic          cmd_valid,
  input  logic [DW-1:0] cmd_duty,
  output logic          cmd_ready,
  input  logic          period_end,
  output logic [DW-1:0] duty_out,
  output logic [DW-1:0] target,
  output logic          busy,
  output logic          err_range
);

  localparam int unsigned EW = DW + 1;
  localparam int unsigned CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [EW-1:0] MIN_E     = EW'(MIN_DUTY);
  localparam logic [EW-1:0] MAX_E     = EW'(MAX_DUTY);
  localparam logic [DW-1:0] DEF_D     = DW'(DEFAULT_DUTY);
  localparam logic [CW-1:0] RAMP_LAST = CW'(RAMP_DIV - 1);

  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] target_q, target_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:0]    state_q, state_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          gnt_valid_c;
  grant_e        gnt_src_c;
  logic          gnt_inc_c;
  logic [DW-1:0] host_val;
  logic [EW-1:0] host_e;
  logic [EW-1:0] target_e;

  pwm_req_arbiter #(.DW(DW)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_pulse_i (inc_pulse),
    .dec_pulse_i (dec_pulse),
    .cmd_valid_i (cmd_valid),
    .cmd_duty_i  (cmd_duty),
    .cmd_ready_o (cmd_ready),
    .gnt_valid_c (gnt_valid_c),
    .gnt_src_c   (gnt_src_c),
    .gnt_inc_c   (gnt_inc_c),
    .host_val_o  (host_val)
  );

  // Duty, target, ramp counter and FSM state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q <= DEF_D;
      cnt_q    <= '0;
      err_q    <= 1'b0;
`ifdef PWM_SOFTSTART_EN
      duty_q   <= '0;
      state_q  <= ST_RAMP;
      busy_q   <= 1'b1;
`else
      duty_q   <= DEF_D;
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
`endif
    end else begin
      duty_q   <= duty_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Target update from the granted request, with clamping and saturation.
  always_comb begin
    target_d = target_q;
    err_d    = 1'b0;
    host_e   = EW'(host_val);
    target_e = EW'(target_q);
    if (gnt_valid_c) begin
      if (gnt_src_c == GNT_HOST) begin
        if (host_e < MIN_E) begin
          target_d = DW'(MIN_E);
          err_d    = 1'b1;
        end else if (host_e > MAX_E) begin
          target_d = DW'(MAX_E);
          err_d    = 1'b1;
        end else begin
          target_d = host_val;
        end
      end else if (gnt_inc_c) begin
        if (target_e < MAX_E) target_d = DW'(target_e + EW'(1));
      end else begin
        if (target_e > MIN_E) target_d = DW'(target_e - EW'(1));
      end
    end
  end

  // Ramp FSM: step duty_out one LSB toward the pre-grant target every RAMP_DIV period ends.
  always_comb begin
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (target_d != duty_q) state_d = ST_RAMP;
      end
      default: begin
        if (period_end) begin
          if (cnt_q == RAMP_LAST) begin
            cnt_d  = '0;
            duty_d = (target_q > duty_q) ? duty_q + DW'(1) : duty_q - DW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        if (duty_d == target_d) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
    busy_d = (state_d == ST_RAMP);
  end

  assign duty_out  = duty_q;
  assign target    = target_q;
  assign busy      = busy_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed self-checking bench for pwm_duty_sequencer (default parameters).
module tb_pwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inc_pulse, dec_pulse, cmd_valid, period_end;
  logic [3:0] cmd_duty;
  logic       cmd_ready, busy, err_range;
  logic [3:0] duty_out, target;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_duty_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .cmd_valid  (cmd_valid),
    .cmd_duty   (cmd_duty),
    .cmd_ready  (cmd_ready),
    .period_end (period_end),
    .duty_out   (duty_out),
    .target     (target),
    .busy       (busy),
    .err_range  (err_range)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    step();
    period_end = 1'b0;
  endtask

  task automatic host_cmd(input logic [3:0] v);
    cmd_valid = 1'b1;
    cmd_duty  = v;
    step();
    cmd_valid = 1'b0;
    step();
  endtask

  task automatic chk_state(input string nm, input logic [3:0] ed, input logic [3:0] et, input logic eb);
    n_vec++;
    if (duty_out !== ed || target !== et || busy !== eb) begin
      n_err++;
      $display("FAIL %s: duty=%0d target=%0d busy=%0b, expected duty=%0d target=%0d busy=%0b",
               nm, duty_out, target, busy, ed, et, eb);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    n_vec++;
    if (cmd_ready !== 1'b1 || err_range !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: cmd_ready=%0b err_range=%0b, expected 1 0", cmd_ready, err_range);
    end
`ifdef PWM_SOFTSTART_EN
    chk_state("reset_soft", 4'd0, 4'd5, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      pulse_pe();
      chk_state("softstart_ramp", 4'(i), 4'd5, (i != 5));
    end
`else
    chk_state("reset_state", 4'd5, 4'd5, 1'b0);
`endif
    for (int i = 0; i < 20; i++) begin
      pulse_pe();
      chk_state("idle_periods", 4'd5, 4'd5, 1'b0);
    end
  endtask

  task automatic test_host_ramp();
    cmd_valid = 1'b1;
    cmd_duty  = 4'd8;
    step();
    cmd_valid = 1'b0;
    n_vec++;
    if (cmd_ready !== 1'b0 || target !== 4'd5) begin
      n_err++;
      $display("FAIL host_accept: cmd_ready=%0b target=%0d, expected 0 5", cmd_ready, target);
    end
    step();
    chk_state("host_grant", 4'd5, 4'd8, 1'b1);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL host_ready_back: cmd_ready=%0b expected 1", cmd_ready);
    end
    step();
    chk_state("no_step_without_pe", 4'd5, 4'd8, 1'b1);
    for (int i = 6; i <= 8; i++) begin
      pulse_pe();
      chk_state("ramp_up", 4'(i), 4'd8, (i != 8));
    end
  endtask

  task automatic test_clamp();
    host_cmd(4'd15);
    n_vec++;
    if (err_range !== 1'b1 || target !== 4'd9) begin
      n_err++;
      $display("FAIL clamp_high: err_range=%0b target=%0d, expected 1 9", err_range, target);
    end
    step();
    n_vec++;
    if (err_range !== 1'b0) begin
      n_err++;
      $display("FAIL err_one_cycle: err_range=%0b expected 0", err_range);
    end
    host_cmd(4'd0);
    n_vec++;
    if (err_range !== 1'b1 || target !== 4'd1) begin
      n_err++;
      $display("FAIL clamp_low: err_range=%0b target=%0d, expected 1 1", err_range, target);
    end
    for (int i = 7; i >= 1; i--) begin
      pulse_pe();
      chk_state("ramp_down", 4'(i), 4'd1, (i != 1));
    end
  endtask

  task automatic test_arbitration();
    dec_pulse = 1'b1;
    step();
    dec_pulse = 1'b0;
    step();
    chk_state("dec_at_min_dropped", 4'd1, 4'd1, 1'b0);
    inc_pulse = 1'b1;
    cmd_valid = 1'b1;
    cmd_duty  = 4'd2;
    step();
    inc_pulse = 1'b0;
    cmd_valid = 1'b0;
    n_vec++;
    if (cmd_ready !== 1'b0 || target !== 4'd1) begin
      n_err++;
      $display("FAIL both_pending: cmd_ready=%0b target=%0d, expected 0 1", cmd_ready, target);
    end
    step();
    n_vec++;
    if (cmd_ready !== 1'b1 || target !== 4'd2) begin
      n_err++;
      $display("FAIL rr_host_first: cmd_ready=%0b target=%0d, expected 1 2", cmd_ready, target);
    end
    step();
    chk_state("rr_button_second", 4'd1, 4'd3, 1'b1);
    pulse_pe();
    pulse_pe();
    chk_state("ramp_to_3", 4'd3, 4'd3, 1'b0);
  endtask

  task automatic test_saturate();
    host_cmd(4'd9);
    chk_state("host_to_max", 4'd3, 4'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      inc_pulse = 1'b1;
      step();
      inc_pulse = 1'b0;
      step();
      chk_state("inc_at_max", 4'd3, 4'd9, 1'b1);
    end
    inc_pulse = 1'b1;
    dec_pulse = 1'b1;
    step();
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;
    step();
    step();
    chk_state("inc_dec_cancel", 4'd3, 4'd9, 1'b1);
    dec_pulse = 1'b1;
    step();
    dec_pulse = 1'b0;
    step();
    chk_state("dec_below_max", 4'd3, 4'd8, 1'b1);
    for (int i = 4; i <= 8; i++) begin
      pulse_pe();
      chk_state("ramp_to_8", 4'(i), 4'd8, (i != 8));
    end
  endtask

  task automatic test_reset_midramp();
    host_cmd(4'd6);
    pulse_pe();
    pulse_pe();
    chk_state("settle_6", 4'd6, 4'd6, 1'b0);
    host_cmd(4'd8);
    pulse_pe();
    chk_state("midramp", 4'd7, 4'd8, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`ifdef PWM_SOFTSTART_EN
    chk_state("midramp_reset_soft", 4'd0, 4'd5, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      pulse_pe();
      chk_state("soft_after_reset", 4'(i), 4'd5, (i != 5));
    end
`else
    chk_state("midramp_reset", 4'd5, 4'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse_pe();
      chk_state("post_reset_hold", 4'd5, 4'd5, 1'b0);
    end
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    inc_pulse  = 1'b0;
    dec_pulse  = 1'b0;
    cmd_valid  = 1'b0;
    cmd_duty   = 4'd0;
    period_end = 1'b0;
    test_reset();
    test_host_ramp();
    test_clamp();
    test_arbitration();
    test_saturate();
    test_reset_midramp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
